// File: rtl/pipeline_pkg.sv
// pipeline_pkg: memory access size encodings shared by the EX/MEM stages
package pipeline_pkg;
    localparam logic [1:0] MEM_SZ_B = 2'd0;
    localparam logic [1:0] MEM_SZ_H = 2'd1;
    localparam logic [1:0] MEM_SZ_W = 2'd2;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port 32-bit SRAM with byte enables and registered read
module dmem_ram #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-3:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);
    logic [31:0] mem [2**(ADDR_W-2)];

    always_ff @(posedge clk)
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (we && be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            rdata <= mem[addr];
        end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage load/store responder with wait states, error checks and lane steering
module dmem_responder
    import pipeline_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_sz,
    input  logic        req_sx,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] wdata;
    } req_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q;
    logic        xfer, err;
    logic [31:0] ram_rdata, ram_wdata, sh, ld_data;
    logic [3:0]  be;
    logic [15:0] h;

    assign req_ready = state_q == IDLE;
    assign xfer      = req_valid && req_ready;
    assign err       = req_q.sz == 2'd3 || (req_q.sz == MEM_SZ_H && req_q.addr[0]) ||
                       (req_q.sz == MEM_SZ_W && req_q.addr[1:0] != 2'd0) || (req_q.addr >> ADDR_W) != '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (xfer) req_q <= '{addr: req_addr, we: req_we, sz: req_sz, sx: req_sx, wdata: req_wdata};
        end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (xfer) begin
                state_d = WAIT_CYCLES > 0 ? WAIT : ACCESS;
                cnt_d   = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
            end
            WAIT: begin
                state_d = cnt_q == 4'd0 ? ACCESS : WAIT;
                cnt_d   = cnt_q == 4'd0 ? cnt_q : cnt_q - 4'd1;
            end
            ACCESS: state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    assign be        = req_q.sz == MEM_SZ_B ? 4'b0001 << req_q.addr[1:0] :
                       req_q.sz == MEM_SZ_H ? (req_q.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign ram_wdata = req_q.sz == MEM_SZ_B ? {4{req_q.wdata[7:0]}} :
                       req_q.sz == MEM_SZ_H ? {2{req_q.wdata[15:0]}} : req_q.wdata;

    dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk  (clk),
        .en   (state_q == ACCESS && !err),
        .we   (req_q.we),
        .be   (be),
        .addr (req_q.addr[ADDR_W-1:2]),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    assign sh      = ram_rdata >> {req_q.addr[1:0], 3'b000};
    assign h       = req_q.addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    assign ld_data = req_q.sz == MEM_SZ_B ? {{24{req_q.sx & sh[7]}}, sh[7:0]} :
                     req_q.sz == MEM_SZ_H ? {{16{req_q.sx & h[15]}}, h} : ram_rdata;

    assign rsp_valid = state_q == RESP;
    assign rsp_err   = rsp_valid && err;
    assign rsp_rdata = rsp_valid && !err && !req_q.we ? ld_data : 32'd0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench over three responders with 1, 0 and 3 wait states
module tb_dmem_responder;
    import pipeline_pkg::*;

    typedef struct {
        int          k;
        logic [31:0] rd;
        logic        er;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid [3];
    logic        req_ready [3];
    logic [31:0] req_addr  [3];
    logic        req_we    [3];
    logic [1:0]  req_sz    [3];
    logic        req_sx    [3];
    logic [31:0] req_wdata [3];
    logic        rsp_valid [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];
    exp_t        exp_q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int wc(int k);
        return k == 0 ? 1 : k == 1 ? 0 : 3;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        int low = 0;
        exp_t e;
        dmem_responder #(.ADDR_W(16), .WAIT_CYCLES(wc(g))) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req_valid(req_valid[g]),
            .req_ready(req_ready[g]),
            .req_addr (req_addr[g]),
            .req_we   (req_we[g]),
            .req_sz   (req_sz[g]),
            .req_sx   (req_sx[g]),
            .req_wdata(req_wdata[g]),
            .rsp_valid(rsp_valid[g]),
            .rsp_rdata(rsp_rdata[g]),
            .rsp_err  (rsp_err[g])
        );
        always @(negedge clk) begin
            if (rsp_valid[g]) begin
                if (exp_q.size() == 0) chk("spurious_rsp", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("rsp_dut", g, e.k);
                    chk("rsp_rdata", rsp_rdata[g], e.rd);
                    chk("rsp_err", rsp_err[g], e.er);
                    chk("rsp_latency", cyc, e.cyc);
                end
            end else chk("idle_out", {rsp_err[g], rsp_rdata[g]}, 0);
            if (!rst_n) low = 0;
            else if (!req_ready[g]) low++;
            else if (low != 0) begin
                chk("ready_low", low, 2 + wc(g));
                low = 0;
            end
        end
    end

    task automatic do_req(input int k, input bit hold, input logic we, input logic [1:0] sz, input logic sx,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] er, input logic ee);
        int n = 0;
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_sz[k]    = sz;
        req_sx[k]    = sx;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[k] && n < 50);
        if (!req_ready[k]) chk("xfer_timeout", req_ready[k], 1);
        else exp_q.push_back('{k, er, ee, cyc + 2 + wc(k)});
        @(posedge clk);
        #1;
        if (!hold) req_valid[k] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            req_valid[k] = 1'b0;
            req_addr[k]  = '0;
            req_we[k]    = 1'b0;
            req_sz[k]    = '0;
            req_sx[k]    = 1'b0;
            req_wdata[k] = '0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", req_ready[k], 1);
            chk("rst_valid", rsp_valid[k], 0);
            chk("rst_rdata", rsp_rdata[k], 0);
            chk("rst_err", rsp_err[k], 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_req(0, 0, 1, MEM_SZ_W, 0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
        do_req(0, 0, 0, MEM_SZ_W, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        do_req(0, 0, 0, MEM_SZ_B, 1, 32'h103, 32'h0, 32'hFFFFFFDE, 0);
        do_req(0, 0, 0, MEM_SZ_B, 0, 32'h103, 32'h0, 32'h000000DE, 0);
        do_req(0, 0, 0, MEM_SZ_H, 1, 32'h100, 32'h0, 32'hFFFFBEEF, 0);
        do_req(0, 0, 0, MEM_SZ_H, 0, 32'h102, 32'h0, 32'h0000DEAD, 0);
        do_req(0, 0, 1, MEM_SZ_B, 0, 32'h101, 32'h0000005A, 32'h0, 0);
        do_req(0, 0, 0, MEM_SZ_W, 0, 32'h100, 32'h0, 32'hDEAD5AEF, 0);
        do_req(0, 0, 0, MEM_SZ_H, 1, 32'h101, 32'h0, 32'h0, 1);
        do_req(0, 0, 1, MEM_SZ_W, 0, 32'h102, 32'h12345678, 32'h0, 1);
        do_req(0, 0, 0, MEM_SZ_W, 0, 32'h100, 32'h0, 32'hDEAD5AEF, 0);
        do_req(0, 0, 0, MEM_SZ_W, 0, 32'h00010000, 32'h0, 32'h0, 1);
        do_req(0, 0, 0, 2'd3, 0, 32'h100, 32'h0, 32'h0, 1);
        do_req(0, 0, 1, MEM_SZ_W, 0, 32'h200, 32'h11223344, 32'h0, 0);
        do_req(0, 0, 1, MEM_SZ_W, 0, 32'h200, 32'hAAAAAAAA, 32'h0, 0);
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", req_ready[0], 1);
        repeat (4) @(posedge clk);
        #1;
        do_req(0, 0, 0, MEM_SZ_W, 0, 32'h200, 32'h0, 32'h11223344, 0);
        drain();
        for (int k = 1; k < 3; k++) begin
            do_req(k, 1, 1, MEM_SZ_W, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0);
            do_req(k, 1, 1, MEM_SZ_B, 0, 32'h43, 32'h00000080, 32'h0, 0);
            do_req(k, 1, 0, MEM_SZ_W, 0, 32'h40, 32'h0, 32'h80FEF00D, 0);
            do_req(k, 0, 0, MEM_SZ_H, 1, 32'h42, 32'h0, 32'hFFFF80FE, 0);
            drain();
        end
        repeat (5) @(posedge clk);
        chk("q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
